// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg
// Shared definitions for the UART packet framer: framer FSM state encoding,
// header layout (byte offsets), header size and the reserved header byte.
// No ports; imported by uart_pkt_framer.
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam int         HDR_BYTES_C     = 4;
    localparam logic [7:0] RESERVED_BYTE_C = 8'h00;

    // Header byte offsets in transmit order.
    localparam logic [1:0] HDR_OPCODE_OFS_C = 2'd0;
    localparam logic [1:0] HDR_RSVD_OFS_C   = 2'd1;
    localparam logic [1:0] HDR_LEN_LO_OFS_C = 2'd2;
    localparam logic [1:0] HDR_LEN_HI_OFS_C = 2'd3;

    // Total frame length as carried in the LEN header field.
    function automatic logic [15:0] frame_len(input logic [15:0] payload_count);
        return 16'(HDR_BYTES_C) + payload_count;
    endfunction

endpackage

// File: rtl/uart_pkt_framer_pkt_buf.sv
// pkt_buf
// Linear payload buffer for one frame. Bytes are written in order from index 0
// and read back in the same order through a read index; clr rewinds both and
// empties the buffer. Storage itself is not reset.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   wr_en       store wr_data at the write pointer (caller guarantees !full)
//   wr_data     byte to store
//   rd_adv      step the read index to the next byte
//   clr         rewind pointers, count back to 0 (wins over wr_en/rd_adv)
//   rd_data     byte at the read index
//   count       number of stored bytes
//   full        count == DEPTH_P
//   rd_last     read index points at the last stored byte
module pkt_buf #(
    parameter int  DATA_WIDTH_P = 8,
    parameter int  DEPTH_P      = 16,
    localparam int CW           = $clog2(DEPTH_P + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH_P-1:0] wr_data,
    input  logic                    rd_adv,
    input  logic                    clr,
    output logic [DATA_WIDTH_P-1:0] rd_data,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    rd_last
);

    localparam int AW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

    logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];
    logic [CW-1:0]           wr_ptr_q;
    logic [CW-1:0]           rd_idx_q;
    logic [CW-1:0]           count_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + CW'(1);
                count_q  <= count_q + CW'(1);
            end
            if (rd_adv) begin
                rd_idx_q <= rd_idx_q + CW'(1);
            end
        end
    end

    assign rd_data = mem[rd_idx_q[AW-1:0]];
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH_P));
    // Only meaningful while count > 0 (the framer skips payload otherwise).
    assign rd_last = (rd_idx_q == (count_q - CW'(1)));

endmodule

// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer
// Buffers payload bytes, then on start_i sends one frame to a UART transmitter:
// opcode, 0x00, LEN[7:0], LEN[15:8] (LEN = 4 + payload count), then the payload
// in write order, followed by GAP_CYCLES_P idle clocks.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   wr_data_i/wr_valid_i/wr_ready_o   payload write port (accepted only in IDLE)
//   opcode_i, start_i            frame request; opcode sampled on accepted start
//   busy_o                       frame (including gap) in progress
//   done_o                       one-cycle pulse when the FSM re-enters IDLE
//   err_o                        one-cycle pulse after a start_i seen while busy
//   m_axis_tdata/tvalid/tready   byte stream to the UART transmitter
//
// Handshake (both ports): a byte transfers on a rising edge where valid and
// ready are both high. Once m_axis_tvalid is high it stays high, with tdata
// unchanged, until that transfer happens.
module uart_pkt_framer
    import uart_pkt_pkg::*;
#(
    parameter int DATA_WIDTH_P = 8,
    parameter int DEPTH_P      = 16,
    parameter int GAP_CYCLES_P = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_P-1:0] wr_data_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [DATA_WIDTH_P-1:0] opcode_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [DATA_WIDTH_P-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int CW       = $clog2(DEPTH_P + 1);
    localparam int GW       = (GAP_CYCLES_P > 1) ? $clog2(GAP_CYCLES_P) : 1;
    localparam int GAP_LAST = (GAP_CYCLES_P > 0) ? GAP_CYCLES_P - 1 : 0;

    state_t                  state_q, state_d;
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH_P-1:0] opcode_q;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    buf_wr_en;
    logic                    buf_rd_adv;
    logic                    buf_clr;
    logic [DATA_WIDTH_P-1:0] buf_rd_data;
    logic [CW-1:0]           buf_count;
    logic                    buf_full;
    logic                    buf_rd_last;

    logic                    start_ok;
    logic                    accept;
    logic                    frame_end;
    logic [15:0]             len;

    pkt_buf #(
        .DATA_WIDTH_P (DATA_WIDTH_P),
        .DEPTH_P      (DEPTH_P)
    ) u_pkt_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr_en),
        .wr_data (wr_data_i),
        .rd_adv  (buf_rd_adv),
        .clr     (buf_clr),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .full    (buf_full),
        .rd_last (buf_rd_last)
    );

    assign wr_ready_o    = (state_q == ST_IDLE) && !buf_full;
    assign buf_wr_en     = wr_valid_i && wr_ready_o;
    assign start_ok      = start_i && (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign m_axis_tvalid = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign accept        = m_axis_tvalid && m_axis_tready;
    // Writes are blocked outside IDLE, so the count is frozen for the whole
    // frame and already includes a write that coincided with the start.
    assign len           = frame_len(16'(buf_count));

    always_comb begin
        m_axis_tdata = '0;
        case (state_q)
            ST_HDR: begin
                case (hdr_idx_q)
                    HDR_OPCODE_OFS_C: m_axis_tdata = opcode_q;
                    HDR_RSVD_OFS_C:   m_axis_tdata = DATA_WIDTH_P'(RESERVED_BYTE_C);
                    HDR_LEN_LO_OFS_C: m_axis_tdata = DATA_WIDTH_P'(len[7:0]);
                    default:          m_axis_tdata = DATA_WIDTH_P'(len[15:8]);
                endcase
            end
            ST_PAYLOAD: m_axis_tdata = buf_rd_data;
            default:    m_axis_tdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hdr_idx_q <= '0;
            gap_cnt_q <= '0;
            opcode_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (start_ok) begin
                opcode_q <= opcode_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        err_d      = busy_o && start_i;
        buf_rd_adv = 1'b0;
        buf_clr    = 1'b0;
        frame_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_HDR;
                    hdr_idx_d = HDR_OPCODE_OFS_C;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (hdr_idx_q == HDR_LEN_HI_OFS_C) begin
                        if (buf_count != '0) begin
                            state_d = ST_PAYLOAD;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    buf_rd_adv = 1'b1;
                    if (buf_rd_last) begin
                        frame_end = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    buf_clr = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Last byte of the frame just transferred: either idle out the gap or
        // finish now. The buffer is emptied on the same edge IDLE is entered.
        if (frame_end) begin
            if (GAP_CYCLES_P == 0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                buf_clr = 1'b1;
            end else begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_framer.sv
// tb_uart_pkt_framer
// Directed bench for uart_pkt_framer. Two instances share the stimulus:
// dut0 uses the defaults (DEPTH 16, no gap), dut1 uses DEPTH 4 and a 3-cycle
// gap. sel picks which instance receives wr_valid/start and is observed.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_uart_pkt_framer;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic [7:0] opcode;
    logic       start;
    logic       tready;
    logic       sel;

    logic       wr_ready0, busy0, done0, err0, tvalid0;
    logic [7:0] tdata0;
    logic       wr_ready1, busy1, done1, err1, tvalid1;
    logic [7:0] tdata1;

    logic       o_wr_ready, o_busy, o_done, o_err, o_tvalid;
    logic [7:0] o_tdata;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    uart_pkt_framer dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_data_i     (wr_data),
        .wr_valid_i    (wr_valid && (sel == 1'b0)),
        .wr_ready_o    (wr_ready0),
        .opcode_i      (opcode),
        .start_i       (start && (sel == 1'b0)),
        .busy_o        (busy0),
        .done_o        (done0),
        .err_o         (err0),
        .m_axis_tdata  (tdata0),
        .m_axis_tvalid (tvalid0),
        .m_axis_tready (tready)
    );

    uart_pkt_framer #(
        .DATA_WIDTH_P (8),
        .DEPTH_P      (4),
        .GAP_CYCLES_P (3)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_data_i     (wr_data),
        .wr_valid_i    (wr_valid && (sel == 1'b1)),
        .wr_ready_o    (wr_ready1),
        .opcode_i      (opcode),
        .start_i       (start && (sel == 1'b1)),
        .busy_o        (busy1),
        .done_o        (done1),
        .err_o         (err1),
        .m_axis_tdata  (tdata1),
        .m_axis_tvalid (tvalid1),
        .m_axis_tready (tready)
    );

    assign o_wr_ready = sel ? wr_ready1 : wr_ready0;
    assign o_busy     = sel ? busy1     : busy0;
    assign o_done     = sel ? done1     : done0;
    assign o_err      = sel ? err1      : err0;
    assign o_tvalid   = sel ? tvalid1   : tvalid0;
    assign o_tdata    = sel ? tdata1    : tdata0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Driver: one write per call, checking wr_ready as seen before the write.
    task automatic write_byte(input logic [7:0] d, input logic exp_ready);
        check_eq("wr_ready", {31'd0, o_wr_ready}, {31'd0, exp_ready});
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Starts a frame and consumes it against exp_q. tmode 0: tready always
    // high; tmode 1: tready toggles, low first. err_at >= 0 pulses start_i
    // on that frame cycle (err expected one cycle later).
    task automatic run_frame(input logic [7:0] op, input int tmode, input int gap,
                             input int err_at, input bit with_wr, input logic [7:0] wr_byte);
        int  cyc;
        bit  exp_err;
        opcode = op;
        start  = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_data  = wr_byte;
        end
        @(negedge clk);
        start    = 1'b0;
        wr_valid = 1'b0;
        cyc      = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            exp_err = (err_at >= 0) && (cyc == err_at + 1);
            check_eq("tvalid", {31'd0, o_tvalid}, 32'd1);
            check_eq("tdata", {24'd0, o_tdata}, {24'd0, exp_q[0]});
            check_eq("busy", {31'd0, o_busy}, 32'd1);
            check_eq("wr_ready_in_frame", {31'd0, o_wr_ready}, 32'd0);
            check_eq("err", {31'd0, o_err}, {31'd0, exp_err});
            tready = (tmode == 0) ? 1'b1 : cyc[0];
            if (o_tvalid && tready) begin
                void'(exp_q.pop_front());
            end
            start = (cyc == err_at);
            if (start) begin
                opcode = 8'hFF;
            end
            @(negedge clk);
            cyc++;
        end
        start  = 1'b0;
        tready = 1'b1;
        check_eq("bytes_left", exp_q.size(), 32'd0);
        exp_q.delete();
        for (int g = 0; g < gap; g++) begin
            check_eq("gap_tvalid", {31'd0, o_tvalid}, 32'd0);
            check_eq("gap_busy", {31'd0, o_busy}, 32'd1);
            check_eq("gap_done", {31'd0, o_done}, 32'd0);
            @(negedge clk);
        end
        check_eq("done_pulse", {31'd0, o_done}, 32'd1);
        check_eq("done_busy", {31'd0, o_busy}, 32'd0);
        check_eq("done_tvalid", {31'd0, o_tvalid}, 32'd0);
        check_eq("done_wr_ready", {31'd0, o_wr_ready}, 32'd1);
        @(negedge clk);
        check_eq("done_clear", {31'd0, o_done}, 32'd0);
        check_eq("err_quiet", {31'd0, o_err}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        opcode   = 8'h00;
        start    = 1'b0;
        tready   = 1'b1;
        sel      = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values on both instances
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check_eq("rst_wr_ready", {31'd0, o_wr_ready}, 32'd1);
            check_eq("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
            check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
            check_eq("rst_done", {31'd0, o_done}, 32'd0);
            check_eq("rst_err", {31'd0, o_err}, 32'd0);
            check_eq("rst_tdata", {24'd0, o_tdata}, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Three bytes written from the first cycle out of reset, back-to-back frame
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        exp_q = '{8'h05, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
        run_frame(8'h05, 0, 0, -1, 1'b0, 8'h00);

        // Empty payload: header only
        exp_q = '{8'h0A, 8'h00, 8'h04, 8'h00};
        run_frame(8'h0A, 0, 0, -1, 1'b0, 8'h00);

        // Write coinciding with start is included; tready toggles
        write_byte(8'hAA, 1'b1);
        write_byte(8'hBB, 1'b1);
        exp_q = '{8'h3C, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        run_frame(8'h3C, 1, 0, -1, 1'b1, 8'hCC);

        // DEPTH 4: fifth write refused; start during frame flags err; 3-cycle gap
        sel = 1'b1;
        write_byte(8'h01, 1'b1);
        write_byte(8'h02, 1'b1);
        write_byte(8'h03, 1'b1);
        write_byte(8'h04, 1'b1);
        write_byte(8'h05, 1'b0);
        check_eq("full_wr_ready", {31'd0, o_wr_ready}, 32'd0);
        exp_q = '{8'h77, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(8'h77, 0, 3, 2, 1'b0, 8'h00);

        // Reset after two payload bytes have gone out
        sel = 1'b0;
        write_byte(8'h41, 1'b1);
        write_byte(8'h42, 1'b1);
        write_byte(8'h43, 1'b1);
        exp_q  = '{8'h09, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        opcode = 8'h09;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_eq("pre_rst_tdata", {24'd0, o_tdata}, {24'd0, exp_q[i]});
            check_eq("pre_rst_tvalid", {31'd0, o_tvalid}, 32'd1);
            if (i < 6) begin
                @(negedge clk);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check_eq("mid_rst_wr_ready", {31'd0, o_wr_ready}, 32'd1);
        check_eq("mid_rst_tdata", {24'd0, o_tdata}, 32'd0);
        check_eq("mid_rst_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Count must be back at 0: an immediate frame carries no payload
        exp_q = '{8'h0B, 8'h00, 8'h04, 8'h00};
        run_frame(8'h0B, 0, 0, -1, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_pkt_framer.md
UART_PKT_FRAMER -- requirements
Module: uart_pkt_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 8, byte width of every data path.
REQ-002 SHALL have parameter DEPTH_P, default 16, payload buffer capacity in bytes; legal range 1..65531.
REQ-003 SHALL have parameter GAP_CYCLES_P, default 0, idle clocks inserted after each frame.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_data_i  input  DATA_WIDTH_P  payload byte to buffer.
REQ-007 SHALL have port wr_valid_i  input  1  payload byte valid.
REQ-008 SHALL have port wr_ready_o  output  1  buffer accepts a byte.
REQ-009 SHALL have port opcode_i  input  DATA_WIDTH_P  frame opcode, sampled on an accepted start.
REQ-010 SHALL have port start_i  input  1  request to transmit one frame.
REQ-011 SHALL have port busy_o  output  1  frame in progress, including the gap.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse at frame completion.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse when start_i is rejected.
REQ-014 SHALL have port m_axis_tdata  output  DATA_WIDTH_P  byte to the UART transmitter.
REQ-015 SHALL have port m_axis_tvalid  output  1  byte valid.
REQ-016 SHALL have port m_axis_tready  input  1  UART transmitter accepts the byte.

Function
REQ-017 SHALL transmit each frame as four header bytes followed by the buffered payload in write order.
REQ-018 SHALL send the header as: opcode, 0x00, LEN[7:0], LEN[15:8], where LEN = 4 + payload count.
REQ-019 SHALL implement states IDLE, HDR, PAYLOAD and GAP.
REQ-020 SHALL move IDLE -> HDR on start_i, and raise m_axis_tvalid with the opcode on the next cycle.
REQ-021 SHALL move HDR -> PAYLOAD when header byte 3 is accepted; with a count of 0 it SHALL instead go to GAP, or to IDLE if GAP_CYCLES_P = 0.
REQ-022 SHALL move PAYLOAD -> GAP after the last payload byte is accepted, or to IDLE if GAP_CYCLES_P = 0.
REQ-023 SHALL stay in GAP for exactly GAP_CYCLES_P cycles with tvalid low, then return to IDLE.
REQ-024 SHALL treat a byte as accepted only when tvalid and tready are both high.
REQ-025 SHALL hold tdata stable and tvalid high while tvalid is high and tready is low.
REQ-026 SHALL sustain one byte per cycle when tready is held high.
REQ-027 SHALL pulse done_o in the cycle the FSM re-enters IDLE, and clear the payload count to 0 in that same cycle.
REQ-028 SHALL drive wr_ready_o high only in IDLE with count < DEPTH_P.
REQ-029 SHALL store a byte and increment the count when wr_valid_i and wr_ready_o are both high.
REQ-030 SHALL, when start_i and an accepted write coincide in IDLE, include that byte in the frame and in LEN.
REQ-031 SHALL ignore start_i while busy_o is high and pulse err_o the next cycle; the frame in progress SHALL NOT be affected.
REQ-032 SHALL keep busy_o high from the cycle after an accepted start until done_o.

Reset
REQ-033 SHALL, on rst_n low, immediately enter IDLE, even mid-frame or mid-gap, with no further bytes sent.
REQ-034 SHALL reset the payload count to 0.
REQ-035 SHALL reset to: wr_ready_o = 1; m_axis_tvalid, busy_o, done_o, err_o = 0; m_axis_tdata = 0.
REQ-036 SHALL be able to accept writes in the first cycle after rst_n deasserts.

Structure
REQ-037 SHALL take the state enum, header byte offsets, HDR_BYTES_C = 4 and RESERVED_BYTE_C = 0x00 from the shared package uart_pkt_pkg.
REQ-038 SHALL hold the payload storage in sub-module pkt_buf: DEPTH_P x DATA_WIDTH_P, with write pointer, read index and count of width $clog2(DEPTH_P+1).
REQ-039 SHALL keep pkt_buf storage unreset; only its pointers and count are reset.

Verification
REQ-040 SHALL cover: write 0x11, 0x22, 0x33, then start with opcode 0x05 and tready held high -> bytes 05 00 07 00 11 22 33 on 7 consecutive cycles, then a done_o pulse.
REQ-041 SHALL cover: start with an empty buffer and opcode 0x0A -> bytes 0A 00 04 00, then done_o.
REQ-042 SHALL cover: tready toggling every other cycle -> no byte lost or duplicated, and tdata stable while stalled.
REQ-043 SHALL cover: DEPTH_P = 4 with 5 writes -> wr_ready_o low after the 4th write, LEN = 0x0008.
REQ-044 SHALL cover: start_i during a frame -> err_o pulses once, frame output unchanged; GAP_CYCLES_P = 3 gives 3 idle cycles before done_o.
REQ-045 SHALL cover: rst_n low after 2 payload bytes have been sent -> tvalid low at once, busy_o = 0, count = 0.
